// File: rtl/pipe_adder_if.sv
// Operand/result stream interface for pipe_adder_param.
// PIPE_ADDER_OVF_EN adds the signed-overflow flag alongside sum.
interface pipe_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef PIPE_ADDER_OVF_EN
   logic             ovf;
`endif

   // Producer/consumer side (drives operands, accepts results)
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
`ifdef PIPE_ADDER_OVF_EN
      input  ovf,
`endif
      input  in_ready, out_valid, sum, cout
   );

   // Adder side
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
`ifdef PIPE_ADDER_OVF_EN
      output ovf,
`endif
      output in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/pipe_adder_param.sv
// Pipelined ripple-carry adder/subtractor, STAGE_BITS resolved per stage, valid/ready flow control.
// Optional signed-overflow output enabled by macro PIPE_ADDER_OVF_EN.
module pipe_adder_param #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned STAGE_BITS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   pipe_adder_if.slave bus
);

   localparam int unsigned NSTAGE = (STAGE_BITS == 0) ? 1 : WIDTH / STAGE_BITS;

   // Elaboration-time parameter sanity
   generate
      if (STAGE_BITS == 0) begin : g_bad_stage_bits
         $error("pipe_adder_param: STAGE_BITS must be non-zero");
      end else if ((WIDTH % STAGE_BITS) != 0 || WIDTH < STAGE_BITS) begin : g_bad_width
         $error("pipe_adder_param: WIDTH (%0d) must be a non-zero multiple of STAGE_BITS (%0d)",
                WIDTH, STAGE_BITS);
      end
   endgenerate

   // Stage 0 holds the raw operands; stage k holds k resolved chunks
   logic [NSTAGE:0]         vld;
   logic [NSTAGE:0]         cry;
   logic [WIDTH-1:0]        opa     [NSTAGE];
   logic [WIDTH-1:0]        opb     [NSTAGE];
   logic [WIDTH-1:0]        res     [1:NSTAGE];
   logic [WIDTH-1:0]        res_nxt [1:NSTAGE];
   logic [STAGE_BITS:0]     chunk   [1:NSTAGE];
   logic                    adv;

   // Whole pipe moves only when the output slot is free or being drained
   assign adv          = ~vld[NSTAGE] | bus.out_ready;
   assign bus.in_ready = adv;

   // Per-stage chunk add and assembly of the resolved low bits
   always_comb begin
      for (int unsigned k = 1; k <= NSTAGE; k++) begin
         chunk[k] = {1'b0, opa[k-1][(k-1)*STAGE_BITS +: STAGE_BITS]}
                  + {1'b0, opb[k-1][(k-1)*STAGE_BITS +: STAGE_BITS]}
                  + (STAGE_BITS+1)'(cry[k-1]);
      end
      res_nxt[1] = WIDTH'(chunk[1][STAGE_BITS-1:0]);
      for (int unsigned k = 2; k <= NSTAGE; k++) begin
         res_nxt[k] = res[k-1];
         res_nxt[k][(k-1)*STAGE_BITS +: STAGE_BITS] = chunk[k][STAGE_BITS-1:0];
      end
   end

`ifdef PIPE_ADDER_OVF_EN
   logic ovf_q;
   logic ovf_nxt;

   // Carry into the MSB is recovered from the MSB operand bits and the MSB sum bit
   assign ovf_nxt = (opa[NSTAGE-1][WIDTH-1] ^ opb[NSTAGE-1][WIDTH-1]
                     ^ chunk[NSTAGE][STAGE_BITS-1]) ^ chunk[NSTAGE][STAGE_BITS];
   assign bus.ovf = ovf_q;
`endif

   // Pipeline registers: shift together on adv, hold everything otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         cry <= '0;
         for (int unsigned k = 0; k < NSTAGE; k++) begin
            opa[k] <= '0;
            opb[k] <= '0;
         end
         for (int unsigned k = 1; k <= NSTAGE; k++) begin
            res[k] <= '0;
         end
`ifdef PIPE_ADDER_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else if (adv) begin
         vld    <= {vld[NSTAGE-1:0], bus.in_valid};
         opa[0] <= bus.a;
         opb[0] <= bus.sub ? ~bus.b : bus.b;
         cry[0] <= bus.sub | bus.cin;
         for (int unsigned k = 1; k < NSTAGE; k++) begin
            opa[k] <= opa[k-1];
            opb[k] <= opb[k-1];
         end
         for (int unsigned k = 1; k <= NSTAGE; k++) begin
            cry[k] <= chunk[k][STAGE_BITS];
            res[k] <= res_nxt[k];
         end
`ifdef PIPE_ADDER_OVF_EN
         ovf_q <= ovf_nxt;
`endif
      end
   end

   assign bus.out_valid = vld[NSTAGE];
   assign bus.sum       = res[NSTAGE];
   assign bus.cout      = cry[NSTAGE];

endmodule

// File: tb/tb_pipe_adder_param.sv
// Self-checking bench for pipe_adder_param: directed vectors, streaming with stall,
// randomized traffic against an arithmetic reference model, and in-flight reset.
module tb_pipe_adder_param;

   localparam int W   = 16;
   localparam int SB  = 4;
   localparam int NST = W / SB;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   pipe_adder_if #(.WIDTH(W)) bus ();

   pipe_adder_param #(.WIDTH(W), .STAGE_BITS(SB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {ovf, cout, sum} from plain integer arithmetic
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
      logic [W-1:0] bb;
      logic [W:0]   full;
      longint       s;
      logic         ov;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : cin);
      s    = longint'($signed(a)) + longint'($signed(bb)) + longint'(sub ? 1 : int'(cin));
      ov   = (s > 32767) || (s < -32768);
      return {ov, full};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.out_ready = 1'b0;
      #3;
      n_total++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      else n_pass++;
      n_total++;
      if (bus.sum !== 16'h0000) $display("FAIL reset_sum: got %h expected 0000", bus.sum);
      else n_pass++;
      n_total++;
      if (bus.cout !== 1'b0) $display("FAIL reset_cout: got %b expected 0", bus.cout);
      else n_pass++;
      n_total++;
      if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      else n_pass++;
`ifdef PIPE_ADDER_OVF_EN
      n_total++;
      if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", bus.ovf);
      else n_pass++;
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [W-1:0] va   [6] = '{16'h0001, 16'hFFFF, 16'h0005, 16'h0005, 16'h7FFF, 16'h8000};
      logic [W-1:0] vb   [6] = '{16'h0001, 16'h0001, 16'h0007, 16'h0007, 16'h0001, 16'hFFFF};
      logic         vc   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic         vs   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [W-1:0] xs   [6] = '{16'h0002, 16'h0000, 16'hFFFE, 16'hFFFE, 16'h8000, 16'h7FFF};
      logic         xc   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic         xo   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.out_ready = 1'b1;
         bus.in_valid = 1'b1; bus.a = va[i]; bus.b = vb[i]; bus.cin = vc[i]; bus.sub = vs[i];
         @(negedge clk);
         bus.in_valid = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom);
         repeat (NST - 1) @(negedge clk);
         n_total++;
         if (bus.out_valid !== 1'b0) $display("FAIL dir%0d_early_valid: got %b expected 0", i, bus.out_valid);
         else n_pass++;
         @(negedge clk);
         n_total++;
         if (bus.out_valid !== 1'b1) $display("FAIL dir%0d_out_valid: got %b expected 1", i, bus.out_valid);
         else n_pass++;
         n_total++;
         if (bus.sum !== xs[i]) $display("FAIL dir%0d_sum: got %h expected %h", i, bus.sum, xs[i]);
         else n_pass++;
         n_total++;
         if (bus.cout !== xc[i]) $display("FAIL dir%0d_cout: got %b expected %b", i, bus.cout, xc[i]);
         else n_pass++;
`ifdef PIPE_ADDER_OVF_EN
         n_total++;
         if (bus.ovf !== xo[i]) $display("FAIL dir%0d_ovf: got %b expected %b", i, bus.ovf, xo[i]);
         else n_pass++;
`else
         if (xo[i] === 1'bx) $display("note: unexpected table entry");
`endif
      end
   endtask

   task automatic test_back_to_back();
      int           sent = 0;
      int           got = 0;
      int           stalls = 0;
      logic [W-1:0] held = '0;
      logic [W-1:0] exp;
      for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
         @(negedge clk);
         if (got == 2 && stalls < 3) begin
            bus.out_ready = 1'b0;
            stalls++;
         end else begin
            bus.out_ready = 1'b1;
         end
         #1;
         if (!bus.out_ready) begin
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
               $display("FAIL b2b_stall_flags: got out_valid=%b in_ready=%b expected 1/0",
                        bus.out_valid, bus.in_ready);
            else n_pass++;
            if (stalls > 1) begin
               n_total++;
               if (bus.sum !== held) $display("FAIL b2b_stall_hold: got %h expected %h", bus.sum, held);
               else n_pass++;
            end
            held = bus.sum;
         end else if (bus.out_valid) begin
            exp = W'(3 * (got + 1));
            n_total++;
            if (bus.sum !== exp || bus.cout !== 1'b0)
               $display("FAIL b2b_result%0d: got %h/%b expected %h/0", got, bus.sum, bus.cout, exp);
            else n_pass++;
            got++;
         end
         if (bus.in_ready && sent < 8) begin
            bus.in_valid = 1'b1; bus.a = W'(sent + 1); bus.b = W'(2 * (sent + 1));
            bus.cin = 1'b0; bus.sub = 1'b0;
            sent++;
         end else if (!bus.in_ready) begin
            bus.in_valid = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom);
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      n_total++;
      if (got != 8 || stalls != 3) $display("FAIL b2b_count: got %0d beats %0d stalls expected 8/3", got, stalls);
      else n_pass++;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic test_random();
      logic [W+1:0] q[$];
      logic [W+1:0] e;
      int           done = 0;
      for (int cyc = 0; cyc < 2000 && done == 0; cyc++) begin
         @(negedge clk);
         bus.out_ready = (cyc < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
         #1;
         n_total++;
         if (bus.in_ready !== (!bus.out_valid || bus.out_ready))
            $display("FAIL rnd_in_ready: got %b expected %b", bus.in_ready, !bus.out_valid || bus.out_ready);
         else n_pass++;
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               n_total++;
               $display("FAIL rnd_spurious: got out_valid=1 expected no pending beat");
            end else begin
               e = q.pop_front();
               n_total++;
               if (bus.sum !== e[W-1:0] || bus.cout !== e[W])
                  $display("FAIL rnd_result: got %h/%b expected %h/%b", bus.sum, bus.cout, e[W-1:0], e[W]);
               else n_pass++;
`ifdef PIPE_ADDER_OVF_EN
               n_total++;
               if (bus.ovf !== e[W+1]) $display("FAIL rnd_ovf: got %b expected %b", bus.ovf, e[W+1]);
               else n_pass++;
`endif
            end
         end
         bus.in_valid = (cyc < 400) && ($urandom_range(0, 2) != 0);
         bus.a = W'($urandom); bus.b = W'($urandom);
         bus.cin = 1'($urandom); bus.sub = 1'($urandom);
         if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
         if (cyc >= 400 && q.size() == 0 && !bus.out_valid) done = 1;
      end
      n_total++;
      if (q.size() != 0) $display("FAIL rnd_drain: got %0d pending beats expected 0", q.size());
      else n_pass++;
   endtask

   task automatic test_reset_inflight();
      int sent = 0;
      int seen = 0;
      @(negedge clk);
      bus.out_ready = 1'b0;
      for (int cyc = 0; cyc < 30 && seen == 0; cyc++) begin
         #1;
         if (bus.out_valid) begin
            seen = 1;
         end else begin
            if (bus.in_ready && sent < 3) begin
               bus.in_valid = 1'b1; bus.a = W'(16'h1234 * (sent + 1)); bus.b = 16'h0F0F;
               bus.cin = 1'b1; bus.sub = 1'b0;
               sent++;
            end else begin
               bus.in_valid = 1'b0;
            end
            @(negedge clk);
         end
      end
      bus.in_valid = 1'b0;
      n_total++;
      if (seen != 1) $display("FAIL rst_fill: got out_valid=%b expected 1 before reset", bus.out_valid);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0000 || bus.cout !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL rst_async: got v=%b s=%h c=%b r=%b expected 0/0000/0/1",
                  bus.out_valid, bus.sum, bus.cout, bus.in_ready);
      else n_pass++;
`ifdef PIPE_ADDER_OVF_EN
      n_total++;
      if (bus.ovf !== 1'b0) $display("FAIL rst_async_ovf: got %b expected 0", bus.ovf);
      else n_pass++;
`endif
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         n_total++;
         if (bus.out_valid !== 1'b0) $display("FAIL rst_stale%0d: got out_valid=%b expected 0", cyc, bus.out_valid);
         else n_pass++;
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_inflight();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
